control_unit: RTL
=================

# control_unit

Hardwired control sequencer for the Mini SRC processor. It replaces the hand-driven control stimulus currently used to exercise `DataPath`. It steps fetch (T0–T2) and per-instruction execute steps (T3–T7), decoding `IR` into the datapath's bus-drive, register-enable, memory and ALU-select signals. It sits beside `DataPath`: it reads `IR` and the branch condition back from it, and drives every control input that `DataPath` exposes.

## Interface
Parameters:
- None. Opcode, ALU code and step encodings live in `src_pkg`.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `clr` in 1: synchronous, active-high reset.
- `ir` in 32: `DataPath` IR. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- `con_ff` in 1: branch-condition flip-flop from `DataPath`.
- `stop` in 1: halt request, sampled only at instruction boundary.
- `Pout`, `MDROut`, `ZLOout`, `HIout`, `LOout`, `Cout`, `BAout` out 1 each: bus drivers.
- `MARen`, `MDRen`, `IRen`, `Yen`, `Pen`, `ZLOen`, `ZHIen` out 1 each: register enables.
- `Read`, `Write` out 1 each: memory strobes. `Read` also selects `Mdatain` into MDR.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `ConIn` out 1 each: register-select and CON logic.
- `alu_control` out 5: ALU operation code.
- `run` out 1: high while executing; low in RESET and HALT.

## Operation
- **State register:** RESET, T0–T7, HALT.
- **Outputs:** pure combinational decode of state and `ir`. Moore in state. `ir` is stable from T3 on. Any signal not listed for a step is 0.
- **Fetch:**
  - T0: `Pout`, `MARen`, `alu_control`=INC, `ZLOen`.
  - T1: `ZLOout`, `Pen`, `Read`, `MDRen`.
  - T2: `MDROut`, `IRen`.
- **R-type (add, sub, and, or):**
  - T3: `Grb`, `Rout`, `Yen`.
  - T4: `Grc`, `Rout`, `alu_control`=opcode, `ZLOen`.
  - T5: `ZLOout`, `Gra`, `Rin`. Then go to T0.
- **Immediate (addi, andi, ori):**
  - T3: `Grb`, `Rout`, `Yen`.
  - T4: `Cout`, `alu_control`=ADD/AND/OR, `ZLOen`.
  - T5: `ZLOout`, `Gra`, `Rin`. Then go to T0.
- **ldi:** T3 `Grb`, `BAout`, `Yen`; T4 `Cout`, ADD, `ZLOen`; T5 `ZLOout`, `Gra`, `Rin`. Then go to T0.
- **ld:**
  - T3–T4 as ldi.
  - T5: `ZLOout`, `MARen`.
  - T6: `Read`, `MDRen`.
  - T7: `MDROut`, `Gra`, `Rin`. Then go to T0.
- **st:**
  - T3–T5 as ld.
  - T6: `Gra`, `Rout`, `MDRen` (`Read`=0).
  - T7: `Write`. Then go to T0.
- **br:**
  - T3: `Gra`, `Rout`, `ConIn`.
  - T4: `Pout`, `Yen`.
  - T5: `Cout`, ADD, `ZLOen`.
  - T6: `ZLOout`; `Pen` only if `con_ff`=1. Then go to T0.
- **jr:** T3 `Gra`, `Rout`, `Pen`. Then go to T0.
- **mfhi / mflo:** T3 `HIout`/`LOout`, `Gra`, `Rin`. Then go to T0.
- **nop and undefined opcodes:** T2 goes directly to T0.
- **halt:** T2 goes to HALT. HALT holds until `clr`.
- **Instruction boundary:** every transition into T0 from T2–T7. If `stop`=1 on that edge, go to HALT instead.

## Timing
- Every step lasts exactly one clock. Signals are valid for the full cycle and the datapath captures them on the closing edge.
- Latency in cycles, fetch included:
  - nop: 3.
  - jr, mfhi, mflo: 4.
  - R-type, immediate, ldi: 6.
  - br: 7.
  - ld, st: 8.
- Memory is single-cycle: `Mdatain` must be valid in any cycle where `Read`=1.
- **Reset:**
  - An edge with `clr`=1 forces RESET from any state, mid-instruction included. No partial write completes after that edge.
  - In RESET, every output is 0, including `alu_control`=00000 and `run`=0.
  - RESET goes to T0 on the first edge with `clr`=0.
- `con_ff` is sampled combinationally in T6 only. It was written at the end of T3.
- `stop` and `clr` asserted on the same edge: `clr` wins.

## Structure
- `src_pkg` holds:
  - Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 01001, or 01010, addi 01011, andi 01100, ori 01101, br 10010, jr 10011, mfhi 10111, mflo 11000, nop 11001, halt 11010.
  - ALU codes: ADD 00011, SUB 00100, AND 01001, OR 01010, INC 11111.
  - State encoding.
- One sub-module: `step_counter`, the state register plus next-state logic. `control_unit` holds the output decode.

## Test plan
- **Reset then fetch:** `clr`=1 for 2 cycles, then released. Expect all outputs 0 and `run`=0 during reset; next cycle T0 asserts `Pout`, `MARen`, `ZLOen` and `alu_control`=11111.
- **addi:** `ir`=0x5A880005 (addi R5,R1,5). Expect T4 `Cout`=1 with `alu_control`=00011, T5 `ZLOout`+`Gra`+`Rin`, and T0 again 6 cycles after the first T0.
- **st then ld:** st takes 8 cycles with `Write`=1 in T7 only; ld has `Read`=1 in T1 and T6 and `Rin` in T7.
- **br:** with `con_ff`=1, T6 shows `Pen`=1; repeated with `con_ff`=0, T6 shows `Pen`=0; both return to T0.
- **stop and halt:** `stop`=1 during the T5 of an add enters HALT with `run`=0; a halt opcode enters HALT after T2; `clr` then restarts at T0.
- **Mid-instruction reset:** `clr` asserted in T5 of ld gives no `Rin` and no `Read` in the following cycle, and outputs go to 0.

Source files
------------

// File: rtl/src_pkg.sv
// Shared encodings for the Mini SRC control sequencer: opcodes, ALU codes, steps.
package src_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned ALU_W = 5;
  localparam int unsigned ST_W  = 4;

  // Instruction word layout; Rc overlaps the upper bits of C.
  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [18:0]     c;
  } ir_fields_t;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_AND = 5'b01001;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'b01010;
  localparam logic [ALU_W-1:0] ALU_INC = 5'b11111;

  localparam logic [ST_W-1:0] ST_RESET = 4'd0;
  localparam logic [ST_W-1:0] ST_T0    = 4'd1;
  localparam logic [ST_W-1:0] ST_T1    = 4'd2;
  localparam logic [ST_W-1:0] ST_T2    = 4'd3;
  localparam logic [ST_W-1:0] ST_T3    = 4'd4;
  localparam logic [ST_W-1:0] ST_T4    = 4'd5;
  localparam logic [ST_W-1:0] ST_T5    = 4'd6;
  localparam logic [ST_W-1:0] ST_T6    = 4'd7;
  localparam logic [ST_W-1:0] ST_T7    = 4'd8;
  localparam logic [ST_W-1:0] ST_HALT  = 4'd9;

  // Final step of each instruction; nop, halt and undefined opcodes end at T2.
  function automatic logic [ST_W-1:0] last_step(input logic [OP_W-1:0] op);
    case (op)
      OP_JR, OP_MFHI, OP_MFLO:                    last_step = ST_T3;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:           last_step = ST_T5;
      OP_BR:                                      last_step = ST_T6;
      OP_LD, OP_ST:                               last_step = ST_T7;
      default:                                    last_step = ST_T2;
    endcase
  endfunction

  // ALU operation for the immediate forms.
  function automatic logic [ALU_W-1:0] imm_alu(input logic [OP_W-1:0] op);
    case (op)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      default: imm_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/step_counter.sv
// Step register for the control sequencer: RESET, T0-T7, HALT.
module step_counter
  import src_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] opcode,
  input  logic            stop,
  output logic [ST_W-1:0] state
);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  logic [ST_W-1:0] boundary;

  // Where an instruction goes when it finishes: next fetch unless halting.
  assign boundary = stop ? ST_HALT : ST_T0;

  // Next-step selection from current step and opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2: begin
        if (opcode == OP_HALT)              state_d = ST_HALT;
        else if (last_step(opcode) == ST_T2) state_d = boundary;
        else                                 state_d = ST_T3;
      end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (last_step(opcode) == state_q) state_d = boundary;
        else                              state_d = ST_W'(state_q + 4'd1);
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // Step register; clr overrides everything, including stop.
  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control unit: step sequencing plus Moore output decode.
module control_unit
  import src_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             stop,
  output logic             Pout,
  output logic             MDROut,
  output logic             ZLOout,
  output logic             HIout,
  output logic             LOout,
  output logic             Cout,
  output logic             BAout,
  output logic             MARen,
  output logic             MDRen,
  output logic             IRen,
  output logic             Yen,
  output logic             Pen,
  output logic             ZLOen,
  output logic             ZHIen,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             ConIn,
  output logic [ALU_W-1:0] alu_control,
  output logic             run
);

  ir_fields_t      ir_f;
  logic [OP_W-1:0] op;
  logic [ST_W-1:0] state;
  logic            unused_ir;

  assign ir_f      = ir_fields_t'(ir);
  assign op        = ir_f.opcode;
  assign unused_ir = ^{ir_f.ra, ir_f.rb, ir_f.c};

  step_counter u_step (
    .clk    (clk),
    .clr    (clr),
    .opcode (op),
    .stop   (stop),
    .state  (state)
  );

  // Control signals for the current step; anything not named stays 0.
  always_comb begin
    Pout = 1'b0; MDROut = 1'b0; ZLOout = 1'b0; HIout = 1'b0; LOout = 1'b0;
    Cout = 1'b0; BAout = 1'b0;
    MARen = 1'b0; MDRen = 1'b0; IRen = 1'b0; Yen = 1'b0; Pen = 1'b0;
    ZLOen = 1'b0; ZHIen = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; ConIn = 1'b0;
    alu_control = '0;
    run = (state != ST_RESET) && (state != ST_HALT);
    case (state)
      ST_T0: begin
        Pout = 1'b1; MARen = 1'b1; alu_control = ALU_INC; ZLOen = 1'b1;
      end
      ST_T1: begin
        ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1;
      end
      ST_T2: begin
        MDROut = 1'b1; IRen = 1'b1;
      end
      ST_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
          end
          OP_LD, OP_LDI, OP_ST: begin
            Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
          end
          OP_BR: begin
            Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
          end
          OP_JR: begin
            Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
          end
          OP_MFHI: begin
            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          OP_MFLO: begin
            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grc = 1'b1; Rout = 1'b1; alu_control = op; ZLOen = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            Cout = 1'b1; alu_control = imm_alu(op); ZLOen = 1'b1;
          end
          OP_LD, OP_LDI, OP_ST: begin
            Cout = 1'b1; alu_control = ALU_ADD; ZLOen = 1'b1;
          end
          OP_BR: begin
            Pout = 1'b1; Yen = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
            ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          OP_LD, OP_ST: begin
            ZLOout = 1'b1; MARen = 1'b1;
          end
          OP_BR: begin
            Cout = 1'b1; alu_control = ALU_ADD; ZLOen = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (op)
          OP_LD: begin
            Read = 1'b1; MDRen = 1'b1;
          end
          OP_ST: begin
            Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
          end
          OP_BR: begin
            ZLOout = 1'b1; Pen = con_ff;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (op)
          OP_LD: begin
            MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          OP_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
